// File: rtl/cpu_trap_ctl_if.sv
// Bundle between the trap sequencer, the pipeline and the CSR file ports.
// slave = the sequencer itself, master = its environment.
interface cpu_trap_ctl_if;
  logic        exc_valid_i;
  logic [4:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_tval_i;
  logic        irq_valid_i;
  logic [4:0]  irq_cause_i;
  logic [31:0] irq_pc_i;
  logic        mret_i;
  logic        trap_ack_o;
  logic        stall_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [11:0] pipe_read_addr_i;
  logic        pipe_read_enable_i;
  logic [31:0] pipe_read_data_o;
  logic [11:0] pipe_write_addr_i;
  logic [31:0] pipe_write_data_i;
  logic        pipe_write_enable_i;
  logic [11:0] csr_read_addr_o;
  logic        csr_read_enable_o;
  logic [31:0] csr_read_data_i;
  logic [11:0] csr_write_addr_o;
  logic [31:0] csr_write_data_o;
  logic        csr_write_enable_o;

  modport slave (
    input  exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
    input  irq_valid_i, irq_cause_i, irq_pc_i, mret_i,
    output trap_ack_o, stall_o, redirect_valid_o, redirect_pc_o,
    input  pipe_read_addr_i, pipe_read_enable_i,
    output pipe_read_data_o,
    input  pipe_write_addr_i, pipe_write_data_i, pipe_write_enable_i,
    output csr_read_addr_o, csr_read_enable_o,
    input  csr_read_data_i,
    output csr_write_addr_o, csr_write_data_o, csr_write_enable_o
  );

  modport master (
    output exc_valid_i, exc_cause_i, exc_pc_i, exc_tval_i,
    output irq_valid_i, irq_cause_i, irq_pc_i, mret_i,
    input  trap_ack_o, stall_o, redirect_valid_o, redirect_pc_o,
    output pipe_read_addr_i, pipe_read_enable_i,
    input  pipe_read_data_o,
    output pipe_write_addr_i, pipe_write_data_i, pipe_write_enable_i,
    input  csr_read_addr_o, csr_read_enable_o,
    output csr_read_data_i,
    input  csr_write_addr_o, csr_write_data_o, csr_write_enable_o
  );
endinterface

// File: rtl/cpu_trap_ctl.sv
// Trap/MRET sequencer: owns the CSR read/write ports, passes pipeline CSR
// traffic through when idle, and issues a one-cycle PC redirect per sequence.
module cpu_trap_ctl (
  input  logic          clk_i,
  input  logic          reset_i,
  cpu_trap_ctl_if.slave bus
);
  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned ST_W    = 4;

  localparam logic [ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [ADDR_W-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [ADDR_W-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [ADDR_W-1:0] CSR_MTVAL   = 12'h343;

  localparam logic [ST_W-1:0] S_IDLE        = 4'd0;
  localparam logic [ST_W-1:0] S_T_RD_STATUS = 4'd1;
  localparam logic [ST_W-1:0] S_T_RD_TVEC   = 4'd2;
  localparam logic [ST_W-1:0] S_T_WR_EPC    = 4'd3;
  localparam logic [ST_W-1:0] S_T_WR_CAUSE  = 4'd4;
  localparam logic [ST_W-1:0] S_T_WR_TVAL   = 4'd5;
  localparam logic [ST_W-1:0] S_T_WR_STATUS = 4'd6;
  localparam logic [ST_W-1:0] S_M_RD_STATUS = 4'd7;
  localparam logic [ST_W-1:0] S_M_RD_EPC    = 4'd8;
  localparam logic [ST_W-1:0] S_M_WR_STATUS = 4'd9;
  localparam logic [ST_W-1:0] S_REDIRECT    = 4'd10;

  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_state_nxt;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_intr;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_tval;
  logic [XLEN-1:0]    r_mstatus;
  logic [XLEN-1:0]    r_mtvec;
  logic [XLEN-1:0]    r_redirect_pc;

  logic               w_ack;
  logic               w_take_exc;
  logic               w_take_irq;
  logic               w_rd_en;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic               w_wr_en;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [XLEN-1:0]    w_wr_data;
  logic [XLEN-1:0]    w_trap_status;
  logic [XLEN-1:0]    w_mret_status;
  logic [XLEN-1:0]    w_mcause;
  logic [XLEN-1:0]    w_trap_base;
  logic [XLEN-1:0]    w_trap_target;

  // mstatus rewrites: MPIE/MIE/MPP are bits 7, 3 and 12:11.
  assign w_trap_status = {r_mstatus[31:13], 2'b11, r_mstatus[10:8], r_mstatus[3],
                          r_mstatus[6:4], 1'b0, r_mstatus[2:0]};
  assign w_mret_status = {r_mstatus[31:13], 2'b00, r_mstatus[10:8], 1'b1,
                          r_mstatus[6:4], r_mstatus[7], r_mstatus[2:0]};
  assign w_mcause      = {r_intr, 26'b0, r_cause};

  // Vectored mode only applies to interrupts; reserved modes fall back to direct.
  assign w_trap_base   = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_target = (r_mtvec[1:0] == 2'b01 && r_intr)
                         ? w_trap_base + XLEN'({r_cause, 2'b00})
                         : w_trap_base;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_take_exc  = 1'b0;
    w_take_irq  = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    w_wr_en     = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    if (!reset_i) begin
      case (r_state)
        S_IDLE: begin
          w_rd_en   = bus.pipe_read_enable_i;
          w_rd_addr = bus.pipe_read_addr_i;
          w_wr_en   = bus.pipe_write_enable_i;
          w_wr_addr = bus.pipe_write_addr_i;
          w_wr_data = bus.pipe_write_data_i;
          if (bus.exc_valid_i || bus.irq_valid_i || bus.mret_i) begin
            w_ack       = 1'b1;
            w_wr_en     = 1'b0;
            w_wr_addr   = '0;
            w_wr_data   = '0;
            w_take_exc  = bus.exc_valid_i;
            w_take_irq  = !bus.exc_valid_i && bus.irq_valid_i;
            w_state_nxt = (bus.exc_valid_i || bus.irq_valid_i) ? S_T_RD_STATUS
                                                               : S_M_RD_STATUS;
          end
        end
        S_T_RD_STATUS: begin
          w_rd_en     = 1'b1;
          w_rd_addr   = CSR_MSTATUS;
          w_state_nxt = S_T_RD_TVEC;
        end
        S_T_RD_TVEC: begin
          w_rd_en     = 1'b1;
          w_rd_addr   = CSR_MTVEC;
          w_state_nxt = S_T_WR_EPC;
        end
        S_T_WR_EPC: begin
          w_wr_en     = 1'b1;
          w_wr_addr   = CSR_MEPC;
          w_wr_data   = r_pc;
          w_state_nxt = S_T_WR_CAUSE;
        end
        S_T_WR_CAUSE: begin
          w_wr_en     = 1'b1;
          w_wr_addr   = CSR_MCAUSE;
          w_wr_data   = w_mcause;
          w_state_nxt = S_T_WR_TVAL;
        end
        S_T_WR_TVAL: begin
          w_wr_en     = 1'b1;
          w_wr_addr   = CSR_MTVAL;
          w_wr_data   = r_tval;
          w_state_nxt = S_T_WR_STATUS;
        end
        S_T_WR_STATUS: begin
          w_wr_en     = 1'b1;
          w_wr_addr   = CSR_MSTATUS;
          w_wr_data   = w_trap_status;
          w_state_nxt = S_REDIRECT;
        end
        S_M_RD_STATUS: begin
          w_rd_en     = 1'b1;
          w_rd_addr   = CSR_MSTATUS;
          w_state_nxt = S_M_RD_EPC;
        end
        S_M_RD_EPC: begin
          w_rd_en     = 1'b1;
          w_rd_addr   = CSR_MEPC;
          w_state_nxt = S_M_WR_STATUS;
        end
        S_M_WR_STATUS: begin
          w_wr_en     = 1'b1;
          w_wr_addr   = CSR_MSTATUS;
          w_wr_data   = w_mret_status;
          w_state_nxt = S_REDIRECT;
        end
        S_REDIRECT: w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Request latches and CSR read captures; read data lags the read by one cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cause       <= '0;
      r_intr        <= 1'b0;
      r_pc          <= '0;
      r_tval        <= '0;
      r_mstatus     <= '0;
      r_mtvec       <= '0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_exc) begin
            r_cause <= bus.exc_cause_i;
            r_intr  <= 1'b0;
            r_pc    <= bus.exc_pc_i;
            r_tval  <= bus.exc_tval_i;
          end else if (w_take_irq) begin
            r_cause <= bus.irq_cause_i;
            r_intr  <= 1'b1;
            r_pc    <= bus.irq_pc_i;
            r_tval  <= '0;
          end
        end
        S_T_RD_TVEC, S_M_RD_EPC: r_mstatus     <= bus.csr_read_data_i;
        S_T_WR_EPC:              r_mtvec       <= bus.csr_read_data_i;
        S_T_WR_STATUS:           r_redirect_pc <= w_trap_target;
        S_M_WR_STATUS:           r_redirect_pc <= {bus.csr_read_data_i[XLEN-1:2], 2'b00};
        default: ;
      endcase
    end
  end

  assign bus.trap_ack_o         = w_ack;
  assign bus.stall_o            = !reset_i && (r_state != S_IDLE);
  assign bus.redirect_valid_o   = !reset_i && (r_state == S_REDIRECT);
  assign bus.redirect_pc_o      = r_redirect_pc;
  assign bus.pipe_read_data_o   = bus.csr_read_data_i;
  assign bus.csr_read_enable_o  = w_rd_en;
  assign bus.csr_read_addr_o    = w_rd_addr;
  assign bus.csr_write_enable_o = w_wr_en;
  assign bus.csr_write_addr_o   = w_wr_addr;
  assign bus.csr_write_data_o   = w_wr_data;
endmodule

// File: tb/tb_cpu_trap_ctl.sv
// Bench for cpu_trap_ctl: CSR-file model with 1-cycle read latency, a
// transaction-level reference model and directed plus random sequences.
module tb_cpu_trap_ctl;
  localparam int K_EXC = 0;
  localparam int K_IRQ = 1;
  localparam int K_MRET = 2;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  logic clk_i = 1'b0;
  logic reset_i;
  cpu_trap_ctl_if bus();
  cpu_trap_ctl dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] mem [0:4095];
  logic [31:0] mdl [int];

  int          ack_q[$], wc_q[$], rc_q[$];
  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$], rp_q[$];
  int          e_ack[$], e_wc[$], e_rc[$];
  logic [11:0] e_wa[$];
  logic [31:0] e_wd[$], e_rp[$];
  int          stall_cnt = 0;
  int          exp_stall = 0;

  // CSR file: write-first, registered read data
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (bus.csr_write_enable_o) mem[bus.csr_write_addr_o] = bus.csr_write_data_o;
    if (bus.csr_read_enable_o)  bus.csr_read_data_i <= mem[bus.csr_read_addr_o];
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (bus.trap_ack_o) ack_q.push_back(cyc);
      if (bus.csr_write_enable_o) begin
        wa_q.push_back(bus.csr_write_addr_o);
        wd_q.push_back(bus.csr_write_data_o);
        wc_q.push_back(cyc);
      end
      if (bus.redirect_valid_o) begin
        rp_q.push_back(bus.redirect_pc_o);
        rc_q.push_back(cyc);
      end
      if (bus.stall_o) stall_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    mem[a] = v;
    mdl[int'(a)] = v;
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [31:0] v, input int at);
    e_wa.push_back(a);
    e_wd.push_back(v);
    e_wc.push_back(at);
    mdl[int'(a)] = v;
  endtask

  // Reference: what one accepted request must do to the CSR file and fetch.
  task automatic mdl_accept(input int kind, input logic [4:0] cause,
                            input logic [31:0] pc, input logic [31:0] tval, input int at);
    logic [31:0] ms, ns, tv, tgt, mc;
    int unsigned mie, mpie;
    ms   = mdl[int'(A_MSTATUS)];
    mie  = (ms >> 3) & 1;
    mpie = (ms >> 7) & 1;
    e_ack.push_back(at);
    if (kind == K_MRET) begin
      ns = (ms & ~32'h0000_1888) | 32'h80 | (mpie * 8);
      exp_wr(A_MSTATUS, ns, at + 3);
      tgt = mdl[int'(A_MEPC)] & ~32'h3;
      e_rp.push_back(tgt);
      e_rc.push_back(at + 4);
      exp_stall += 4;
    end else begin
      tv = (kind == K_IRQ) ? 32'h0 : tval;
      mc = ((kind == K_IRQ) ? 32'h8000_0000 : 32'h0) + 32'(cause);
      ns = (ms & ~32'h0000_1888) | 32'h1800 | (mie * 128);
      exp_wr(A_MEPC, pc, at + 3);
      exp_wr(A_MCAUSE, mc, at + 4);
      exp_wr(A_MTVAL, tv, at + 5);
      exp_wr(A_MSTATUS, ns, at + 6);
      tgt = mdl[int'(A_MTVEC)] & ~32'h3;
      if ((mdl[int'(A_MTVEC)] & 32'h3) == 32'h1 && kind == K_IRQ) tgt = tgt + 32'(cause) * 4;
      e_rp.push_back(tgt);
      e_rc.push_back(at + 7);
      exp_stall += 7;
    end
  endtask

  task automatic clear_logs();
    ack_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete(); rp_q.delete(); rc_q.delete();
    e_ack.delete(); e_wa.delete(); e_wd.delete(); e_wc.delete(); e_rp.delete(); e_rc.delete();
    stall_cnt = 0;
    exp_stall = 0;
  endtask

  task automatic finish_txn(input string tag);
    chk({tag, ".n_ack"}, 64'(ack_q.size()), 64'(e_ack.size()));
    chk({tag, ".n_wr"},  64'(wa_q.size()),  64'(e_wa.size()));
    chk({tag, ".n_redir"}, 64'(rp_q.size()), 64'(e_rp.size()));
    chk({tag, ".stall"}, 64'(stall_cnt), 64'(exp_stall));
    for (int i = 0; i < ack_q.size() && i < e_ack.size(); i++)
      chk({tag, ".ack_cyc"}, 64'(ack_q[i]), 64'(e_ack[i]));
    for (int i = 0; i < wa_q.size() && i < e_wa.size(); i++) begin
      chk({tag, ".wr_addr"}, 64'(wa_q[i]), 64'(e_wa[i]));
      chk({tag, ".wr_data"}, 64'(wd_q[i]), 64'(e_wd[i]));
      chk({tag, ".wr_cyc"},  64'(wc_q[i]), 64'(e_wc[i]));
    end
    for (int i = 0; i < rp_q.size() && i < e_rp.size(); i++) begin
      chk({tag, ".redir_pc"},  64'(rp_q[i]), 64'(e_rp[i]));
      chk({tag, ".redir_cyc"}, 64'(rc_q[i]), 64'(e_rc[i]));
    end
    clear_logs();
  endtask

  task automatic drive_req(input int kind, input logic [4:0] cause,
                           input logic [31:0] pc, input logic [31:0] tval);
    if (kind == K_EXC) begin
      bus.exc_valid_i = 1'b1; bus.exc_cause_i = cause; bus.exc_pc_i = pc; bus.exc_tval_i = tval;
    end else if (kind == K_IRQ) begin
      bus.irq_valid_i = 1'b1; bus.irq_cause_i = cause; bus.irq_pc_i = pc;
    end else begin
      bus.mret_i = 1'b1;
    end
  endtask

  task automatic drop_reqs();
    bus.exc_valid_i = 1'b0;
    bus.irq_valid_i = 1'b0;
    bus.mret_i      = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && bus.stall_o; k++) begin
      @(posedge clk_i); #1;
    end
    chk("seq_end", 64'(bus.stall_o), 64'(0));
  endtask

  // Called 1 time unit after a rising edge with the DUT idle.
  task automatic run_one(input int kind, input logic [4:0] cause,
                         input logic [31:0] pc, input logic [31:0] tval);
    mdl_accept(kind, cause, pc, tval, cyc);
    drive_req(kind, cause, pc, tval);
    @(posedge clk_i); #1;
    drop_reqs();
    wait_idle();
  endtask

  task automatic init_csrs();
    set_csr(A_MSTATUS, 32'h0000_0008);
    set_csr(A_MTVEC,   32'h0000_1001);
    set_csr(A_MEPC,    32'h0);
    set_csr(A_MCAUSE,  32'h0);
    set_csr(A_MTVAL,   32'h0);
  endtask

  initial begin
    int c;
    reset_i = 1'b1;
    drop_reqs();
    bus.exc_cause_i = '0; bus.exc_pc_i = '0; bus.exc_tval_i = '0;
    bus.irq_cause_i = '0; bus.irq_pc_i = '0;
    bus.pipe_read_addr_i = '0; bus.pipe_read_enable_i = 1'b0;
    bus.pipe_write_addr_i = '0; bus.pipe_write_data_i = '0; bus.pipe_write_enable_i = 1'b0;
    init_csrs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.ack",   64'(bus.trap_ack_o), 64'(0));
    chk("rst.stall", 64'(bus.stall_o), 64'(0));
    chk("rst.rv",    64'(bus.redirect_valid_o), 64'(0));
    chk("rst.rpc",   64'(bus.redirect_pc_o), 64'(0));
    chk("rst.wen",   64'(bus.csr_write_enable_o), 64'(0));
    chk("rst.ren",   64'(bus.csr_read_enable_o), 64'(0));
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    clear_logs();

    // exception entry, direct mtvec
    run_one(K_EXC, 5'd2, 32'h100, 32'hDEAD);
    chk("exc.mepc",   64'(wd_q[0]), 64'h100);
    chk("exc.mcause", 64'(wd_q[1]), 64'h2);
    chk("exc.mtval",  64'(wd_q[2]), 64'hDEAD);
    chk("exc.mstat",  64'(wd_q[3]), 64'h1880);
    chk("exc.target", 64'(rp_q[0]), 64'h1000);
    chk("exc.lat",    64'(rc_q[0] - ack_q[0]), 64'(7));
    finish_txn("exc");

    // vectored interrupt
    set_csr(A_MTVEC, 32'h0000_2001);
    run_one(K_IRQ, 5'd7, 32'h204, 32'h0);
    chk("irq.mcause", 64'(wd_q[1]), 64'h8000_0007);
    chk("irq.mtval",  64'(wd_q[2]), 64'h0);
    chk("irq.target", 64'(rp_q[0]), 64'h201C);
    finish_txn("irq");

    // MRET
    set_csr(A_MSTATUS, 32'h0000_1880);
    set_csr(A_MEPC,    32'h0000_0106);
    run_one(K_MRET, 5'd0, 32'h0, 32'h0);
    chk("mret.mstat",  64'(wd_q[0]), 64'h88);
    chk("mret.wr_lat", 64'(wc_q[0] - ack_q[0]), 64'(3));
    chk("mret.target", 64'(rp_q[0]), 64'h104);
    chk("mret.lat",    64'(rc_q[0] - ack_q[0]), 64'(4));
    finish_txn("mret");

    // simultaneous requests with a pipeline write pending
    set_csr(A_MSTATUS, 32'h0000_0008);
    set_csr(A_MTVEC,   32'h0000_3001);
    c = cyc;
    mdl_accept(K_EXC, 5'd11, 32'h400, 32'h77, c);
    mdl_accept(K_IRQ, 5'd3, 32'h500, 32'h0, c + 8);
    drive_req(K_EXC, 5'd11, 32'h400, 32'h77);
    drive_req(K_IRQ, 5'd3, 32'h500, 32'h0);
    drive_req(K_MRET, 5'd0, 32'h0, 32'h0);
    bus.pipe_write_addr_i = A_MTVAL; bus.pipe_write_data_i = 32'h5555; bus.pipe_write_enable_i = 1'b1;
    #1;
    chk("simul.ack0", 64'(bus.trap_ack_o), 64'(1));
    chk("simul.wsup0", 64'(bus.csr_write_enable_o), 64'(0));
    @(posedge clk_i); #1;
    bus.exc_valid_i = 1'b0;
    bus.mret_i = 1'b0;
    repeat (7) begin @(posedge clk_i); #1; end
    chk("simul.ack1", 64'(bus.trap_ack_o), 64'(1));
    chk("simul.wsup1", 64'(bus.csr_write_enable_o), 64'(0));
    @(posedge clk_i); #1;
    drop_reqs();
    bus.pipe_write_enable_i = 1'b0;
    wait_idle();
    finish_txn("simul");

    // pass-through in idle
    bus.pipe_write_addr_i = A_MTVEC; bus.pipe_write_data_i = 32'h4000; bus.pipe_write_enable_i = 1'b1;
    bus.pipe_read_addr_i = A_MSTATUS; bus.pipe_read_enable_i = 1'b1;
    #1;
    chk("pt.waddr", 64'(bus.csr_write_addr_o), 64'(A_MTVEC));
    chk("pt.wdata", 64'(bus.csr_write_data_o), 64'h4000);
    chk("pt.wen",   64'(bus.csr_write_enable_o), 64'(1));
    chk("pt.raddr", 64'(bus.csr_read_addr_o), 64'(A_MSTATUS));
    chk("pt.ren",   64'(bus.csr_read_enable_o), 64'(1));
    @(posedge clk_i); #1;
    bus.pipe_write_enable_i = 1'b0; bus.pipe_read_enable_i = 1'b0;
    mdl[int'(A_MTVEC)] = 32'h4000;
    chk("pt.rdata", 64'(bus.pipe_read_data_o), 64'(mem[A_MSTATUS]));
    chk("pt.mem",   64'(mem[A_MTVEC]), 64'h4000);
    clear_logs();

    // pipeline write during T_WR_CAUSE is dropped
    c = cyc;
    mdl_accept(K_EXC, 5'd13, 32'h800, 32'h1111, c);
    drive_req(K_EXC, 5'd13, 32'h800, 32'h1111);
    @(posedge clk_i); #1;
    drop_reqs();
    repeat (3) begin @(posedge clk_i); #1; end
    bus.pipe_write_addr_i = 12'h7C0; bus.pipe_write_data_i = 32'h1234; bus.pipe_write_enable_i = 1'b1;
    #1;
    chk("drop.waddr", 64'(bus.csr_write_addr_o), 64'(A_MCAUSE));
    chk("drop.wdata", 64'(bus.csr_write_data_o), 64'd13);
    @(posedge clk_i); #1;
    bus.pipe_write_enable_i = 1'b0;
    wait_idle();
    finish_txn("drop");

    // reset mid-sequence
    drive_req(K_EXC, 5'd4, 32'h900, 32'h22);
    @(posedge clk_i); #1;
    drop_reqs();
    repeat (3) begin @(posedge clk_i); #1; end
    bus.pipe_write_addr_i = A_MTVAL; bus.pipe_write_data_i = 32'h99; bus.pipe_write_enable_i = 1'b1;
    #1;
    reset_i = 1'b1;
    #1;
    chk("mrst.stall", 64'(bus.stall_o), 64'(0));
    chk("mrst.wen",   64'(bus.csr_write_enable_o), 64'(0));
    chk("mrst.waddr", 64'(bus.csr_write_addr_o), 64'(0));
    chk("mrst.wdata", 64'(bus.csr_write_data_o), 64'(0));
    chk("mrst.ren",   64'(bus.csr_read_enable_o), 64'(0));
    chk("mrst.raddr", 64'(bus.csr_read_addr_o), 64'(0));
    chk("mrst.rpc",   64'(bus.redirect_pc_o), 64'(0));
    chk("mrst.rv",    64'(bus.redirect_valid_o), 64'(0));
    chk("mrst.ack",   64'(bus.trap_ack_o), 64'(0));
    @(posedge clk_i); #1;
    bus.pipe_write_enable_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    clear_logs();
    init_csrs();
    repeat (10) begin @(posedge clk_i); #1; end
    chk("mrst.no_redir", 64'(rp_q.size()), 64'(0));
    clear_logs();
    run_one(K_EXC, 5'd6, 32'hA00, 32'h33);
    finish_txn("post_rst");

    // randomized sequences
    for (int n = 0; n < 40; n++) begin
      int kind;
      set_csr(A_MSTATUS, $urandom);
      set_csr(A_MTVEC, $urandom);
      set_csr(A_MEPC, $urandom);
      kind = int'($urandom_range(0, 2));
      run_one(kind, 5'($urandom), $urandom, $urandom);
      finish_txn("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_trap_ctl.md
# cpu_trap_ctl

Trap sequencer for the RISC-V core. It owns the CSR file's single read port and single write port. It arbitrates them between the pipeline (pass-through when idle) and its own trap entry and MRET sequences. For each trap or MRET it reads `mstatus` and `mtvec`/`mepc`, writes `mepc`, `mcause`, `mtval` and `mstatus`, then issues a one-cycle PC redirect to fetch while stalling the pipeline.

## Interface
Parameters: none. CSR addresses come from `common::csr_t` constants: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343.

- clk_i  in  1  clock
- reset_i  in  1  reset; one clock; asynchronous, active-high
- exc_valid_i  in  1  synchronous exception request (level)
- exc_cause_i  in  5  exception cause code
- exc_pc_i  in  32  PC of the faulting instruction
- exc_tval_i  in  32  trap value
- irq_valid_i  in  1  qualified interrupt request (level; pipeline has already gated it with MIE/mie)
- irq_cause_i  in  5  interrupt cause code
- irq_pc_i  in  32  PC to resume at after the interrupt
- mret_i  in  1  MRET retiring (level)
- trap_ack_o  out  1  one-cycle pulse: request accepted
- stall_o  out  1  pipeline must hold
- redirect_valid_o  out  1  one-cycle PC redirect strobe
- redirect_pc_o  out  32  redirect target
- pipe_read_addr_i  in  12  pipeline CSR read address
- pipe_read_enable_i  in  1  pipeline CSR read enable
- pipe_read_data_o  out  32  CSR read data returned to the pipeline
- pipe_write_addr_i  in  12  pipeline CSR write address
- pipe_write_data_i  in  32  pipeline CSR write data
- pipe_write_enable_i  in  1  pipeline CSR write enable
- csr_read_addr_o  out  12  to CSR file read port
- csr_read_enable_o  out  1  to CSR file read port
- csr_read_data_i  in  32  from CSR file; registered, 1-cycle latency
- csr_write_addr_o  out  12  to CSR file write port
- csr_write_data_o  out  32  to CSR file write port
- csr_write_enable_o  out  1  to CSR file write port

## Operation
- **States:** IDLE, T_RD_STATUS, T_RD_TVEC, T_WR_EPC, T_WR_CAUSE, T_WR_TVAL, T_WR_STATUS, M_RD_STATUS, M_RD_EPC, M_WR_STATUS, REDIRECT.
- **IDLE:** pipeline ports pass combinationally to the CSR ports. `pipe_read_data_o = csr_read_data_i` at all times.
- **Acceptance in IDLE:** priority is exc > irq > mret. Lower-priority requests are ignored that cycle and must be held by the requester.
- **On accept:**
  - Pulse `trap_ack_o`.
  - Suppress the pipeline write that cycle (`csr_write_enable_o` = 0).
  - Latch cause, PC and tval. For an interrupt, tval = 0 and interrupt flag = 1.
  - Next state is T_RD_STATUS for exc/irq, M_RD_STATUS for mret.
- **Trap entry path:**
  - T_RD_STATUS: read MSTATUS.
  - T_RD_TVEC: capture `mstatus`; read MTVEC.
  - T_WR_EPC: capture `mtvec`; write MEPC = latched PC.
  - T_WR_CAUSE: write MCAUSE = {intr, 26'b0, cause}.
  - T_WR_TVAL: write MTVAL.
  - T_WR_STATUS: write `mstatus` with bit7 (MPIE) = old bit3 (MIE), bit3 = 0, bits[12:11] (MPP) = 2'b11, other bits unchanged.
  - Then REDIRECT.
- **MRET path:**
  - M_RD_STATUS: read MSTATUS.
  - M_RD_EPC: capture `mstatus`; read MEPC.
  - M_WR_STATUS: capture `mepc`; write `mstatus` with bit3 = old bit7, bit7 = 1, bits[12:11] = 2'b00.
  - Then REDIRECT.
- **Trap target:** base = {mtvec[31:2], 2'b00}. If mtvec[1:0] == 2'b01 and intr, target = base + {cause, 2'b00}; otherwise target = base. Addition is 32-bit and wraps mod 2^32. Reserved modes 2'b10 and 2'b11 are treated as direct.
- **MRET target:** {mepc[31:2], 2'b00}.
- **REDIRECT:** `redirect_valid_o` = 1 and `redirect_pc_o` = target for exactly one cycle, then IDLE. `redirect_pc_o` holds its value until the next redirect.
- **Outside IDLE:** pipeline read and write requests are ignored (not forwarded). Requests arriving during a sequence are not queued.

## Timing
- `stall_o` = 1 in every state except IDLE. It is 0 in the accept cycle; `trap_ack_o` covers that cycle.
- Trap: accept at cycle N; `csr_write_enable_o` high in N+3, N+4, N+5, N+6; redirect at N+7; IDLE at N+8.
- MRET: accept at N; write at N+3; redirect at N+4; IDLE at N+5.
- Back-to-back: a request held through REDIRECT is accepted in the first IDLE cycle.
- **Reset values** (asynchronous, immediate, also mid-sequence): state = IDLE; `trap_ack_o`, `stall_o`, `redirect_valid_o`, `csr_read_enable_o` and `csr_write_enable_o` = 0; `redirect_pc_o`, `csr_read_addr_o`, `csr_write_addr_o`, `csr_write_data_o` and all latches = 0. A sequence interrupted by reset is abandoned; no redirect is issued.
- While reset is asserted, pipeline pass-through is also forced off.

## Test plan
- **Exception entry:** mtvec = 0x0000_1001, mstatus = 0x0000_0008; exc cause 2, pc 0x100, tval 0xDEAD → writes MEPC = 0x100, MCAUSE = 0x2, MTVAL = 0xDEAD, MSTATUS = 0x1880; redirect 0x1000 at N+7; `stall_o` high N+1..N+7.
- **Vectored interrupt:** mtvec = 0x0000_2001; irq cause 7, pc 0x204 → MCAUSE = 0x8000_0007, MTVAL = 0, redirect 0x201C.
- **MRET:** mstatus = 0x0000_1880, mepc = 0x0000_0106 → MSTATUS = 0x0000_0088 written at N+3; redirect 0x104 at N+4.
- **Simultaneous requests:** exc, irq and mret all asserted in one cycle → exc accepted; irq (held) accepted at N+8; the pipeline write asserted in both accept cycles is not forwarded.
- **Pass-through:** in IDLE, pipeline write 0x305 ← 0x4000 reaches the CSR port in the same cycle. In state T_WR_CAUSE a pipeline write is dropped and the port carries the MCAUSE write.
- **Reset mid-sequence:** assert `reset_i` in T_WR_CAUSE → all outputs 0 without a clock edge; no redirect; a new exc after release completes normally.
